// File: rtl/adc_spi_rx.sv
// SPI receiver for an ADC: synchronizes the asynchronous SPI clock/data into fpga_clock,
// assembles MSB-first frames of DATA_WIDTH bits, and discards frames that stall too long.
`timescale 1ns/1ps
module adc_spi_rx #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  fpga_clock,
  input  logic                  rstn,
  input  logic                  adc_spi_clock,
  input  logic                  adc_spi_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_error,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            sclk_sync;
  logic [1:0]            sdata_sync;
  logic                  spi_rise;
  logic                  spi_bit;

  logic [0:0]            state, state_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n, bit_cnt_inc;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n, shifted;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  rx_valid_n, rx_error_n, busy_n;

  // Data takes the same two stages as the clock so the sampled bit lines up with the edge
  always_ff @(posedge fpga_clock) begin
    if (!rstn) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], adc_spi_clock};
      sdata_sync <= {sdata_sync[0], adc_spi_data};
    end
  end

  assign spi_rise    = sclk_sync[1] & ~sclk_sync[2];
  assign spi_bit     = sdata_sync[1];
  assign shifted     = {shift_q[DATA_WIDTH-2:0], spi_bit};
  assign bit_cnt_inc = bit_cnt + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge fpga_clock) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      shift_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      to_cnt   <= to_cnt_n;
      shift_q  <= shift_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_error <= rx_error_n;
      busy     <= busy_n;
    end
  end

  // Next-state logic; a detected edge always takes priority over timeout expiry
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    to_cnt_n   = to_cnt;
    shift_n    = shift_q;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_error_n = 1'b0;

    case (state)
      IDLE: begin
        if (spi_rise) begin
          shift_n   = DATA_WIDTH'(spi_bit);
          bit_cnt_n = CNT_W'(1);
          to_cnt_n  = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (spi_rise) begin
          shift_n   = shifted;
          bit_cnt_n = bit_cnt_inc;
          to_cnt_n  = '0;
          if (bit_cnt_inc == CNT_LAST) begin
            rx_data_n  = shifted;
            rx_valid_n = 1'b1;
            bit_cnt_n  = '0;
            state_n    = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          rx_error_n = 1'b1;
          bit_cnt_n  = '0;
          to_cnt_n   = '0;
          shift_n    = '0;
          state_n    = IDLE;
        end else if (to_cnt != '1) begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        to_cnt_n  = '0;
      end
    endcase

    busy_n = (state_n == SHIFT);
  end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Scoreboard bench for adc_spi_rx: one instance with slow asynchronous SPI timing and one
// with TIMEOUT_CYCLES=8 driven cycle-accurately so every edge lands exactly on timeout expiry.
`timescale 1ns/1ps
module tb_adc_spi_rx;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
  } exp_t;

  logic        fclk;
  logic        rstn;
  logic        sck1, sd1, sck2, sd2;
  logic [15:0] rx_data1, rx_data2;
  logic        v1, e1, b1, v2, e2, b2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t ex1, ex2;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  real  last_rise = 0.0;

  adc_spi_rx #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(1024)) u_dut1 (
    .fpga_clock(fclk), .rstn(rstn), .adc_spi_clock(sck1), .adc_spi_data(sd1),
    .rx_data(rx_data1), .rx_valid(v1), .rx_error(e1), .busy(b1)
  );

  adc_spi_rx #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) u_dut2 (
    .fpga_clock(fclk), .rstn(rstn), .adc_spi_clock(sck2), .adc_spi_data(sd2),
    .rx_data(rx_data2), .rx_valid(v2), .rx_error(e2), .busy(b2)
  );

  // 133 MHz system clock
  initial fclk = 1'b0;
  always #3.75 fclk = ~fclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Asynchronous SPI master for dut1, 375 ns half-period
  task automatic send1(input logic [15:0] w, input int nbits, input bit lat_chk);
    int n;
    for (int i = 0; i < nbits; i++) begin
      sd1 = w[15-i];
      #375;
      sck1 = 1'b1;
      last_rise = $realtime;
      if (i == 8) begin
        #100;
        chk("busy_mid_frame", 32'(b1), 32'd1);
        #275;
      end else if (lat_chk && i == nbits - 1) begin
        n = 0;
        while (n < 8 && !v1) begin
          @(posedge fclk);
          #1;
          n++;
        end
        chk("valid_latency_within_4", 32'(n <= 4), 32'd1);
        #300;
      end else begin
        #375;
      end
      sck1 = 1'b0;
    end
  endtask

  // Cycle-aligned SPI master for dut2: rising edges exactly 8 fpga_clock cycles apart
  task automatic send2(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge fclk);
      sd2  = w[15-i];
      sck2 = 1'b1;
      repeat (4) @(negedge fclk);
      sck2 = 1'b0;
      repeat (3) @(negedge fclk);
    end
  endtask

  // Monitors: pop and compare whenever a DUT reports a word or an error
  always @(negedge fclk) begin
    if (v1 || e1) begin
      chk("dut1_valid_error_exclusive", 32'(v1 & e1), 32'd0);
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected_event: valid=%0b error=%0b data=0x%0h", v1, e1, rx_data1);
      end else begin
        ex1 = q1.pop_front();
        chk("dut1_event_kind_is_err", 32'(e1), 32'(ex1.is_err));
        chk("dut1_rx_data", 32'(rx_data1), 32'(ex1.data));
      end
    end
  end

  always @(negedge fclk) begin
    if (v2 || e2) begin
      chk("dut2_valid_error_exclusive", 32'(v2 & e2), 32'd0);
      if (q2.size() == 0) begin
        total_cnt++;
        $display("FAIL dut2_unexpected_event: valid=%0b error=%0b data=0x%0h", v2, e2, rx_data2);
      end else begin
        ex2 = q2.pop_front();
        chk("dut2_event_kind_is_err", 32'(e2), 32'(ex2.is_err));
        chk("dut2_rx_data", 32'(rx_data2), 32'(ex2.data));
      end
    end
  end

  initial begin
    int n;
    int cyc;
    rstn = 1'b0;
    sck1 = 1'b0; sd1 = 1'b0;
    sck2 = 1'b0; sd2 = 1'b0;
    repeat (5) @(negedge fclk);
    chk("reset_rx_data1", 32'(rx_data1), 32'd0);
    chk("reset_valid1", 32'(v1), 32'd0);
    chk("reset_error1", 32'(e1), 32'd0);
    chk("reset_busy1", 32'(b1), 32'd0);
    chk("reset_rx_data2", 32'(rx_data2), 32'd0);
    chk("reset_busy2", 32'(b2), 32'd0);
    rstn = 1'b1;
    #1.3;

    // Single frame
    q1.push_back('{1'b0, 16'h5533});
    send1(16'h5533, 16, 1'b1);
    #750;
    chk("busy_after_frame", 32'(b1), 32'd0);

    // Truncated frame times out, holds rx_data, then a good frame follows
    q1.push_back('{1'b1, 16'h5533});
    send1(16'h96AA, 15, 1'b0);
    n = 0;
    while (!e1 && n < 1200) begin
      @(posedge fclk);
      #1;
      n++;
    end
    chk("timeout_error_seen", 32'(e1), 32'd1);
    cyc = int'(($realtime - last_rise) / 7.5);
    chk("timeout_delay_in_range", 32'(cyc >= 1024 && cyc <= 1030), 32'd1);
    #750;
    q1.push_back('{1'b0, 16'h1655});
    send1(16'h1655, 16, 1'b0);
    #750;

    // Back-to-back frames with one half-period gap
    q1.push_back('{1'b0, 16'h96AA});
    q1.push_back('{1'b0, 16'h5533});
    q1.push_back('{1'b0, 16'h1655});
    send1(16'h96AA, 16, 1'b0);
    #375;
    send1(16'h5533, 16, 1'b0);
    #375;
    send1(16'h1655, 16, 1'b0);
    #750;

    // Reset in the middle of a frame
    send1(16'hAAAA, 8, 1'b0);
    chk("busy_before_reset", 32'(b1), 32'd1);
    @(negedge fclk);
    rstn = 1'b0;
    repeat (3) @(negedge fclk);
    chk("busy_in_reset", 32'(b1), 32'd0);
    chk("rx_data_in_reset", 32'(rx_data1), 32'd0);
    rstn = 1'b1;
    #1.3;
    q1.push_back('{1'b0, 16'h00FF});
    send1(16'h00FF, 16, 1'b0);
    #750;

    // Every edge coincides with timeout expiry; then a real stall must time out
    q2.push_back('{1'b0, 16'hC3A5});
    send2(16'hC3A5, 16);
    repeat (10) @(negedge fclk);
    chk("dut2_busy_after_frame", 32'(b2), 32'd0);
    q2.push_back('{1'b1, 16'hC3A5});
    send2(16'hA000, 3);
    repeat (30) @(negedge fclk);

    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
    chk("dut1_busy_final", 32'(b1), 32'd0);
    chk("dut2_busy_final", 32'(b2), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, meaning the number of bits per frame.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of fpga_clock cycles allowed between detected SPI rising edges inside a frame.
REQ-003 The module SHALL have port fpga_clock, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port adc_spi_clock, input, 1 bit: SPI serial clock, asynchronous to fpga_clock, idle low.
REQ-006 The module SHALL have port adc_spi_data, input, 1 bit: SPI serial data, asynchronous, MSB first, valid at the adc_spi_clock rising edge.
REQ-007 The module SHALL have port rx_data, output, DATA_WIDTH bits: the last complete received word.
REQ-008 The module SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-009 The module SHALL have port rx_error, output, 1 bit: one-cycle pulse when a partial frame is discarded.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a frame is in progress (state SHIFT).

Function
REQ-011 The module SHALL pass adc_spi_clock and adc_spi_data through two-flop synchronizers of equal depth, plus one extra clock stage for edge detection.
REQ-012 The module SHALL detect an SPI rising edge when the synchronized clock is 1 and its previous stage is 0, and SHALL sample the synchronized data in that same cycle.
REQ-013 The module SHALL ignore falling edges of adc_spi_clock.
REQ-014 The module SHALL implement states IDLE and SHIFT.
REQ-015 In IDLE, a detected rising edge SHALL load the sampled bit as the MSB, set the bit count to 1, clear the timeout counter, and enter SHIFT.
REQ-016 In SHIFT, each detected rising edge SHALL shift the sampled bit in at the LSB end, increment the bit count, and clear the timeout counter.
REQ-017 When the bit count reaches DATA_WIDTH, rx_data SHALL be loaded with the assembled word and rx_valid SHALL be high for exactly one cycle.
REQ-018 rx_valid SHALL assert no more than 4 fpga_clock cycles after the adc_spi_clock pin edge that carries the final bit.
REQ-019 On frame completion the state SHALL return to IDLE in the same cycle that rx_valid asserts.
REQ-020 In SHIFT, the timeout counter SHALL increment on every cycle with no detected rising edge.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1, the module SHALL pulse rx_error for one cycle, discard the partial word, leave rx_data unchanged, and return to IDLE.
REQ-022 If a rising edge and timeout expiry coincide in the same cycle, the edge SHALL win: the bit is accepted and no error is raised.
REQ-023 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-024 rx_valid and rx_error SHALL never be high in the same cycle.
REQ-025 A rising edge in the cycle after completion SHALL start a new frame with no bit lost.
REQ-026 The timeout counter width SHALL be clog2(TIMEOUT_CYCLES).
REQ-027 The bit counter width SHALL be clog2(DATA_WIDTH+1).

Reset
REQ-028 When rstn is low at a fpga_clock edge, the module SHALL set state to IDLE, rx_data to 0, rx_valid, rx_error and busy to 0, and clear the counters, the shift register and the synchronizer stages to 0.
REQ-029 Reset mid-frame SHALL discard the partial word without pulsing rx_error.
REQ-030 After rstn rises, the first detected rising edge SHALL begin a new frame.

Verification
REQ-031 Send 0x5533 MSB first, 375 ns half-period, fpga_clock 133 MHz -> a single rx_valid pulse, rx_data = 0x5533, busy low afterwards, rx_error never asserted.
REQ-032 Send only 15 bits of 0x96AA, then idle -> rx_error pulses once TIMEOUT_CYCLES after the last edge, no rx_valid, rx_data holds its previous value, and the next full frame 0x1655 is received correctly.
REQ-033 Send 0x96AA, 0x5533 and 0x1655 back-to-back with one half-period gap -> three rx_valid pulses carrying those values in order, with no rx_error.
REQ-034 Assert rstn low after 8 bits of 0xAAAA, release it, then send 0x00FF -> no rx_valid or rx_error from the aborted frame, then rx_valid with rx_data = 0x00FF.
REQ-035 Force the detected edge to coincide with timeout expiry (TIMEOUT_CYCLES = 8, gap tuned) -> bit accepted, no rx_error, word completes correctly.
